exposure_controller: RTL and testbench



---
 rtl/camera_pkg.sv | 68 ++++++
 rtl/exposure_timer.sv | 32 +++
 rtl/exposure_controller.sv | 107 ++++++++++
 tb/tb_exposure_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// Shared types and constants for the camera exposure controller.
//   EXP_W / EXP_MIN / EXP_MAX / EXP_DEFAULT : exposure value width and limits
//   state_t       : frame-sequencing states
//   frame_out_t   : bundle of the pixel-array / ADC control outputs
//   decode_outputs: output pattern for each state
package camera_pkg;

   localparam int EXP_W       = 6;
   localparam int EXP_MIN     = 2;
   localparam int EXP_MAX     = 30;
   localparam int EXP_DEFAULT = 8;

   typedef enum logic [2:0] {
      IDLE,
      EXPOSE,
      R1_SEL,
      R1_ADC,
      R1_HOLD,
      R2_SEL,
      R2_ADC,
      R2_HOLD
   } state_t;

   typedef struct packed {
      logic erase;
      logic expose;
      logic nre_1;
      logic nre_2;
      logic adc;
      logic busy;
      logic frame_done;
   } frame_out_t;

   // nre_1 and nre_2 are active low; adc only fires while one row is selected.
   function automatic frame_out_t decode_outputs(input state_t st);
      frame_out_t o;
      o = '{erase: 1'b0, expose: 1'b0, nre_1: 1'b1, nre_2: 1'b1,
            adc: 1'b0, busy: 1'b1, frame_done: 1'b0};
      case (st)
         IDLE: begin
            o.erase = 1'b1;
            o.busy  = 1'b0;
         end
         EXPOSE:  o.expose = 1'b1;
         R1_SEL:  o.nre_1  = 1'b0;
         R1_ADC: begin
            o.nre_1 = 1'b0;
            o.adc   = 1'b1;
         end
         R1_HOLD: o.nre_1  = 1'b0;
         R2_SEL:  o.nre_2  = 1'b0;
         R2_ADC: begin
            o.nre_2 = 1'b0;
            o.adc   = 1'b1;
         end
         R2_HOLD: begin
            o.nre_2      = 1'b0;
            o.frame_done = 1'b1;
         end
         default: begin
            o.erase = 1'b1;
            o.busy  = 1'b0;
         end
      endcase
      return o;
   endfunction

endpackage

// File: rtl/exposure_timer.sv
// Exposure down-counter (responder side of the exposure-timer interface).
//   clk, reset : clock and asynchronous active-high reset
//   load       : load load_val into the counter
//   load_val   : exposure length in cycles (>= 1)
//   en         : decrement by one this cycle
//   last       : counter currently holds 1 (final exposure cycle)
module exposure_timer
   import camera_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [EXP_W-1:0] load_val,
   input  logic             en,
   output logic             last
);

   logic [EXP_W-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (en && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign last = (r_count == EXP_W'(1));

endmodule

// File: rtl/exposure_controller.sv
// Camera frame sequencer: holds the user exposure setting and walks the pixel
// array through erase -> expose -> row-1 readout -> row-2 readout.
//   clk, reset        : clock and asynchronous active-high reset
//   init              : start a frame (IDLE only, wins over adjust)
//   exp_increase/_dec : adjust exposure by one per cycle (IDLE only)
//   exp_time          : current exposure setting
//   erase, expose     : pixel erase / integrate (active high)
//   nre_1, nre_2      : row read enables (active low)
//   adc               : ADC convert strobe
//   busy, frame_done  : not-IDLE flag, last-readout-cycle pulse
//
// state   | meaning
// IDLE    | pixels held in erase, exposure adjustable, waiting for init
// EXPOSE  | integrating for exp_time cycles
// R1_SEL  | row 1 selected
// R1_ADC  | row 1 converting
// R1_HOLD | row 1 settle
// R2_SEL  | row 2 selected
// R2_ADC  | row 2 converting
// R2_HOLD | row 2 settle, frame_done
module exposure_controller
   import camera_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             init,
   input  logic             exp_increase,
   input  logic             exp_decrease,
   output logic [EXP_W-1:0] exp_time,
   output logic             erase,
   output logic             expose,
   output logic             nre_1,
   output logic             nre_2,
   output logic             adc,
   output logic             busy,
   output logic             frame_done
);

   localparam logic [EXP_W-1:0] EXP_MIN_V     = EXP_W'(EXP_MIN);
   localparam logic [EXP_W-1:0] EXP_MAX_V     = EXP_W'(EXP_MAX);
   localparam logic [EXP_W-1:0] EXP_DEFAULT_V = EXP_W'(EXP_DEFAULT);

   state_t           r_state;
   state_t           w_state_next;
   frame_out_t       r_out;
   logic [EXP_W-1:0] r_exp_time;
   logic             w_timer_load;
   logic             w_timer_en;
   logic             w_timer_last;

   assign w_timer_load = (r_state == IDLE) && init;
   assign w_timer_en   = (r_state == EXPOSE);

   exposure_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (w_timer_load),
      .load_val (r_exp_time),
      .en       (w_timer_en),
      .last     (w_timer_last)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (init) w_state_next = EXPOSE;
         EXPOSE:  if (w_timer_last) w_state_next = R1_SEL;
         R1_SEL:  w_state_next = R1_ADC;
         R1_ADC:  w_state_next = R1_HOLD;
         R1_HOLD: w_state_next = R2_SEL;
         R2_SEL:  w_state_next = R2_ADC;
         R2_ADC:  w_state_next = R2_HOLD;
         R2_HOLD: w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with r_state
   // and never see a combinational path from the inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_out      <= decode_outputs(IDLE);
         r_exp_time <= EXP_DEFAULT_V;
      end else begin
         r_state <= w_state_next;
         r_out   <= decode_outputs(w_state_next);
         if ((r_state == IDLE) && !init) begin
            if (exp_increase && !exp_decrease) begin
               if (r_exp_time < EXP_MAX_V) r_exp_time <= r_exp_time + 1'b1;
            end else if (exp_decrease && !exp_increase) begin
               if (r_exp_time > EXP_MIN_V) r_exp_time <= r_exp_time - 1'b1;
            end
         end
      end
   end

   assign exp_time   = r_exp_time;
   assign erase      = r_out.erase;
   assign expose     = r_out.expose;
   assign nre_1      = r_out.nre_1;
   assign nre_2      = r_out.nre_2;
   assign adc        = r_out.adc;
   assign busy       = r_out.busy;
   assign frame_done = r_out.frame_done;

endmodule

// File: tb/tb_exposure_controller.sv
// Self-checking bench for exposure_controller: table-driven adjustment vectors,
// hand-written frame / reset / back-to-back sequences, and random stimulus
// compared each cycle against a frame-schedule reference model.
module tb_exposure_controller;
   import camera_pkg::*;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             init = 1'b0;
   logic             exp_increase = 1'b0;
   logic             exp_decrease = 1'b0;
   logic [EXP_W-1:0] exp_time;
   logic             erase, expose, nre_1, nre_2, adc, busy, frame_done;

   exposure_controller dut (
      .clk          (clk),
      .reset        (reset),
      .init         (init),
      .exp_increase (exp_increase),
      .exp_decrease (exp_decrease),
      .exp_time     (exp_time),
      .erase        (erase),
      .expose       (expose),
      .nre_1        (nre_1),
      .nre_2        (nre_2),
      .adc          (adc),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: a queue of the remaining cycles of the current frame,
   // each entry being the expected output pattern; empty queue means idle.
   typedef struct {
      bit erase, expose, nre_1, nre_2, adc, busy, fd;
   } exp_t;

   exp_t q[$];
   int   m_exp = 8;

   typedef struct {
      bit    i, inc, dec;
      int    n;
      int    exp_after;
      string name;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
      end
   endtask

   task automatic check_all(input string tag);
      exp_t e;
      if (q.size() != 0) e = q[0];
      else e = '{1, 0, 1, 1, 0, 0, 0};
      chk({tag, ".exp_time"},   32'(exp_time),   32'(m_exp));
      chk({tag, ".erase"},      32'(erase),      32'(e.erase));
      chk({tag, ".expose"},     32'(expose),     32'(e.expose));
      chk({tag, ".nre_1"},      32'(nre_1),      32'(e.nre_1));
      chk({tag, ".nre_2"},      32'(nre_2),      32'(e.nre_2));
      chk({tag, ".adc"},        32'(adc),        32'(e.adc));
      chk({tag, ".busy"},       32'(busy),       32'(e.busy));
      chk({tag, ".frame_done"}, 32'(frame_done), 32'(e.fd));
   endtask

   task automatic model_update(input bit i, input bit inc, input bit dec);
      if (q.size() != 0) begin
         void'(q.pop_front());
      end else if (i) begin
         for (int k = 0; k < m_exp; k++) q.push_back('{0, 1, 1, 1, 0, 1, 0});
         q.push_back('{0, 0, 0, 1, 0, 1, 0});
         q.push_back('{0, 0, 0, 1, 1, 1, 0});
         q.push_back('{0, 0, 0, 1, 0, 1, 0});
         q.push_back('{0, 0, 1, 0, 0, 1, 0});
         q.push_back('{0, 0, 1, 0, 1, 1, 0});
         q.push_back('{0, 0, 1, 0, 0, 1, 1});
      end else if (inc && !dec) begin
         if (m_exp < EXP_MAX) m_exp = m_exp + 1;
      end else if (dec && !inc) begin
         if (m_exp > EXP_MIN) m_exp = m_exp - 1;
      end
   endtask

   // Called at a falling edge; drives inputs, advances model, checks at next falling edge.
   task automatic cycle(input bit i, input bit inc, input bit dec, input string tag);
      init         = i;
      exp_increase = inc;
      exp_decrease = dec;
      model_update(i, inc, dec);
      @(posedge clk);
      @(negedge clk);
      check_all(tag);
   endtask

   // Asserts reset between edges and checks outputs before any clock edge.
   task automatic async_reset(input string tag);
      init = 1'b0;
      exp_increase = 1'b0;
      exp_decrease = 1'b0;
      #2 reset = 1'b1;
      #1;
      q.delete();
      m_exp = EXP_DEFAULT;
      check_all(tag);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic measure_frame(input int expect_exp, input string tag);
      int n_exp, n_busy, n_r1, n_r2, n_adc, n_fd;
      n_exp = 0; n_busy = 0; n_r1 = 0; n_r2 = 0; n_adc = 0; n_fd = 0;
      for (int k = 0; k < 20; k++) begin
         cycle(k == 0, 1'b0, 1'b0, tag);
         n_exp  += int'(expose);
         n_busy += int'(busy);
         n_r1   += int'(!nre_1);
         n_r2   += int'(!nre_2);
         n_adc  += int'(adc);
         n_fd   += int'(frame_done);
      end
      chk({tag, ".expose_cycles"}, 32'(n_exp),  32'(expect_exp));
      chk({tag, ".busy_cycles"},   32'(n_busy), 32'(expect_exp + 6));
      chk({tag, ".nre1_cycles"},   32'(n_r1),   32'd3);
      chk({tag, ".nre2_cycles"},   32'(n_r2),   32'd3);
      chk({tag, ".adc_cycles"},    32'(n_adc),  32'd2);
      chk({tag, ".done_cycles"},   32'(n_fd),   32'd1);
   endtask

   // Structural invariants, independent of the model.
   always @(negedge clk) begin
      if (!reset) begin
         if (!nre_1 && !nre_2) begin
            failures++;
            $display("FAIL both_nre_low actual=00 expected=not00 t=%0t", $time);
         end
         if (adc && (nre_1 == nre_2)) begin
            failures++;
            $display("FAIL adc_without_row actual=%b%b expected=one_low t=%0t", nre_1, nre_2, $time);
         end
      end
   end

   initial begin
      int idle_cnt;

      vecs[0] = '{0, 1, 0, 30, 30, "inc_sat"};
      vecs[1] = '{0, 0, 1, 40, 2,  "dec_sat"};
      vecs[2] = '{0, 1, 1, 5,  2,  "inc_dec_both"};
      vecs[3] = '{0, 1, 0, 3,  5,  "inc3"};
      vecs[4] = '{0, 0, 0, 4,  5,  "no_adjust"};
      vecs[5] = '{0, 0, 1, 1,  4,  "dec1"};

      // Power-on reset state.
      @(negedge clk);
      q.delete();
      m_exp = EXP_DEFAULT;
      check_all("por");
      reset = 1'b0;
      cycle(0, 0, 0, "post_por");

      async_reset("reset");

      measure_frame(8, "frame_default");

      for (int v = 0; v < 6; v++) begin
         for (int k = 0; k < vecs[v].n; k++)
            cycle(vecs[v].i, vecs[v].inc, vecs[v].dec, vecs[v].name);
         chk({vecs[v].name, ".table"}, 32'(exp_time), 32'(vecs[v].exp_after));
      end

      for (int k = 0; k < 2; k++) cycle(0, 0, 1, "to_min");
      chk("at_min", 32'(exp_time), 32'd2);
      measure_frame(2, "frame_min");

      // init with increase: frame starts, setting unchanged; adjust/init ignored mid-frame.
      cycle(1, 1, 0, "init_inc");
      chk("init_inc.exp_time", 32'(exp_time), 32'd2);
      chk("init_inc.expose",   32'(expose),   32'd1);
      cycle(0, 1, 0, "inc_in_expose");
      for (int k = 0; k < 3; k++) cycle(1, 0, 0, "init_in_readout");
      for (int k = 0; k < 10; k++) cycle(0, 0, 0, "drain");
      chk("after_ignored.exp_time", 32'(exp_time), 32'd2);
      chk("after_ignored.busy",     32'(busy),     32'd0);

      // Mid-frame reset in the 4th exposure cycle at exp_time=10.
      async_reset("pre_mid");
      cycle(0, 1, 0, "to10");
      cycle(0, 1, 0, "to10");
      chk("at10", 32'(exp_time), 32'd10);
      cycle(1, 0, 0, "mid_exp1");
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, "mid_exp");
      chk("mid_exp4.expose", 32'(expose), 32'd1);
      async_reset("mid_reset");
      for (int k = 0; k < 12; k++) cycle(0, 0, 0, "after_mid_reset");

      // Back-to-back frames with init held.
      idle_cnt = 0;
      for (int k = 0; k < 28; k++) begin
         cycle(1, 0, 0, "b2b");
         idle_cnt += int'(!busy);
      end
      chk("b2b.idle_cycles", 32'(idle_cnt), 32'd1);
      for (int k = 0; k < 20; k++) cycle(0, 0, 0, "b2b_drain");

      // Random stimulus against the model.
      for (int k = 0; k < 3000; k++)
         cycle($urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), "rand");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
